key_event_conditioner: RTL and testbench



---
 rtl/key_pkg.sv | 31 +++
 rtl/key_debounce_channel.sv | 200 ++++++++++++++++++++
 rtl/key_event_conditioner.sv | 49 ++++
 tb/tb_key_event_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event conditioner: debounce FSM state
// encoding, default timing constants and the counter width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package key_pkg;

    // Debounce FSM states, one per channel.
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } key_state_e;

    // 1 ms and 1 s at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd50000;
    localparam int unsigned HOLD_CYCLES_DEF     = 32'd50000000;

    // Number of bits needed to hold values 0 .. n-1 (at least 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < n) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// -----------------------------------------------------------------------------
// key_debounce_channel
// One push-button channel: 2-flop synchronizer, 4-state debounce FSM and
// registered press/release (and optional long-press) event pulses.
// Optional feature macro: LONG_PRESS_EN (adds the hold counter and hold_pulse_o).
//
// Ports:
//   clk_i            system clock
//   rst_n_i          synchronous active-low reset
//   key_n_i          raw asynchronous button, 0 = pressed
//   pressed_o        debounced level, 1 = pressed
//   press_pulse_o    one-cycle pulse on accepted press
//   release_pulse_o  one-cycle pulse on accepted release
//   hold_pulse_o     one-cycle pulse on long press (0 without LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic hold_pulse_o
);

    localparam logic [1:0] ST_RELEASED     = RELEASED;
    localparam logic [1:0] ST_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] ST_HELD         = HELD;
    localparam logic [1:0] ST_RELEASE_WAIT = RELEASE_WAIT;

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // The terminal-count compare needs at least two cycles to be meaningful.
    generate
        if ((DEBOUNCE_CYCLES < 32'd2) || (HOLD_CYCLES < 32'd1)) begin : g_bad_param
            $error("key_debounce_channel: DEBOUNCE_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
        end
    endgenerate

    logic             s1_q;
    logic             s2_q;
    logic             k_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_q;
    logic             pressed_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Synchronized key, 1 = pressed.
    assign k_s = ~s2_q;

    // Debounce FSM next-state: a new level is accepted only after it has been
    // seen for DEBOUNCE_CYCLES consecutive cycles; any dip back restarts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (k_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!k_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HELD;
                    cnt_d     = '0;
                    press_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!k_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (k_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_RELEASED;
                cnt_d     = '0;
                pressed_d = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM and registered event outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_n_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

`ifdef LONG_PRESS_EN
    // hcnt can reach HOLD_CYCLES, where it parks after the single hold pulse.
    localparam int unsigned       HCNT_W    = cnt_width(HOLD_CYCLES + 32'd1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = {{(HCNT_W-1){1'b0}}, 1'b1};
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(HOLD_CYCLES);

    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic              hold_q;
    logic              hold_d;

    // Hold counter: runs while debounced-pressed, fires once, cleared in
    // RELEASED/PRESS_WAIT so every accepted press starts from zero.
    always_comb begin
        hcnt_d = hcnt_q;
        hold_d = 1'b0;
        if ((state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT)) begin
            if (hcnt_q == HCNT_LAST) begin
                hold_d = 1'b1;
                hcnt_d = HCNT_SAT;
            end else if (hcnt_q != HCNT_SAT) begin
                hcnt_d = hcnt_q + HCNT_ONE;
            end else begin
                hcnt_d = hcnt_q;
            end
            if (state_d == ST_RELEASED) begin
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_d;
            end
        end else begin
            hcnt_d = '0;
        end
    end

    // Hold counter and registered hold pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hcnt_q <= '0;
            hold_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold_pulse_o = hold_q;
`else
    assign hold_pulse_o = 1'b0;
`endif

endmodule

// File: rtl/key_event_conditioner.sv
// -----------------------------------------------------------------------------
// key_event_conditioner
// Turns the raw active-low DE10-Lite KEY buttons into debounced levels and
// single-cycle press/release/hold events. Channels are fully independent.
// Optional feature macro: LONG_PRESS_EN (enables hold_pulse).
//
// Ports:
//   MAX10_CLK1_50  system clock, 50 MHz
//   rst_n          synchronous active-low reset
//   KEY            raw asynchronous buttons, 0 = pressed
//   pressed        debounced level, 1 = pressed
//   press_pulse    one-cycle pulse on accepted press
//   release_pulse  one-cycle pulse on accepted release
//   hold_pulse     one-cycle pulse on long press (0 without LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module key_event_conditioner
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] hold_pulse
);

    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
            key_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_CYCLES     (HOLD_CYCLES)
            ) u_chan (
                .clk_i           (MAX10_CLK1_50),
                .rst_n_i         (rst_n),
                .key_n_i         (KEY[g]),
                .pressed_o       (pressed[g]),
                .press_pulse_o   (press_pulse[g]),
                .release_pulse_o (release_pulse[g]),
                .hold_pulse_o    (hold_pulse[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_event_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_event_conditioner
// Self-checking bench: directed scenarios followed by randomized button
// activity, compared every cycle against a run-length reference model.
// -----------------------------------------------------------------------------
module tb_key_event_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int H = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] hold_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: sync delay line, accepted level, run length of
    // samples disagreeing with the accepted level, and press time stamps.
    logic [N-1:0] s1_m;
    logic [N-1:0] s2_m;
    logic [N-1:0] stable_m;
    logic [N-1:0] exp_pp;
    logic [N-1:0] exp_rp;
    logic [N-1:0] exp_hp;
    int           run_m [N];
    int           press_edge [N];
    int           edge_n = 0;

    key_event_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .KEY           (key),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     tag, obs, obs, exp_v, exp_v, $time);
        end
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        edge_n++;
        if (!rst_n) begin
            s1_m     = '1;
            s2_m     = '1;
            stable_m = '0;
            exp_pp   = '0;
            exp_rp   = '0;
            exp_hp   = '0;
            for (int i = 0; i < N; i++) begin
                run_m[i]      = 0;
                press_edge[i] = -1000000;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit k_m;
                k_m = ~s2_m[i];
                exp_pp[i] = 1'b0;
                exp_rp[i] = 1'b0;
                exp_hp[i] = 1'b0;
`ifdef LONG_PRESS_EN
                if (stable_m[i] && (edge_n - press_edge[i] == H)) exp_hp[i] = 1'b1;
`endif
                if (k_m != stable_m[i]) begin
                    run_m[i]++;
                    if (run_m[i] == D) begin
                        stable_m[i] = k_m;
                        run_m[i]    = 0;
                        if (k_m) begin
                            exp_pp[i]     = 1'b1;
                            press_edge[i] = edge_n;
                            stable_m[i]   = 1'b1;
                        end else begin
                            exp_rp[i] = 1'b1;
                        end
                    end
                end else begin
                    run_m[i] = 0;
                end
            end
            s2_m = s1_m;
            s1_m = key;
        end
    endtask

    // One clock: update the model at the edge, compare all outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("pressed",       32'(pressed),       32'(stable_m));
        check_eq("press_pulse",   32'(press_pulse),   32'(exp_pp));
        check_eq("release_pulse", 32'(release_pulse), 32'(exp_rp));
        check_eq("hold_pulse",    32'(hold_pulse),    32'(exp_hp));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count clocks until the chosen pulse appears on a channel (bounded).
    task automatic measure(input int ch, input bit want_press, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if ((want_press ? press_pulse[ch] : release_pulse[ch]) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int flip_div;

        key   = 2'b11;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            run_m[i]      = 0;
            press_edge[i] = -1000000;
        end
        s1_m = '1; s2_m = '1; stable_m = '0;
        exp_pp = '0; exp_rp = '0; exp_hp = '0;
        #1;

        // Reset and idle.
        steps(3);
        check_eq("reset_outputs", 32'({pressed, press_pulse, release_pulse, hold_pulse}), 32'd0);
        rst_n = 1'b1;
        steps(10);

        // Clean press then release on KEY[0].
        key[0] = 1'b0;
        measure(0, 1'b1, lat);
        check_eq("press_latency", 32'(lat), 32'd6);
        check_eq("pressed_after_press", 32'(pressed), 32'b01);
        steps(5);
        key[0] = 1'b1;
        measure(0, 1'b0, lat);
        check_eq("release_latency", 32'(lat), 32'd6);
        check_eq("pressed_after_release", 32'(pressed), 32'b00);
        steps(8);

        // Bounce shorter than the debounce window: no event.
        key[0] = 1'b0; steps(3);
        key[0] = 1'b1; steps(1);
        key[0] = 1'b0; steps(3);
        key[0] = 1'b1; steps(10);
        check_eq("bounce_no_press", 32'(pressed), 32'b00);

        // Simultaneous press and release on both keys.
        key = 2'b00;
        measure(1, 1'b1, lat);
        check_eq("simul_press", 32'(press_pulse), 32'b11);
        steps(6);
        key = 2'b11;
        measure(0, 1'b0, lat);
        check_eq("simul_release", 32'(release_pulse), 32'b11);
        steps(6);

        // Reset in the middle of a press debounce on KEY[1].
        key[1] = 1'b0; steps(3);
        rst_n = 1'b0; steps(1);
        rst_n = 1'b1;
        measure(1, 1'b1, lat);
        check_eq("press_after_reset_latency", 32'(lat), 32'd6);
        key[1] = 1'b1; steps(10);

        // Long press on KEY[0].
        key[0] = 1'b0; steps(40);
        key[0] = 1'b1; steps(10);

        // Random activity: bouncy phases and long-hold phases, rare resets.
        for (int c = 0; c < 4000; c++) begin
            flip_div = ((c / 500) % 2 == 0) ? 3 : 40;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(flip_div - 1, 0) == 0) key[i] = ~key[i];
            end
            rst_n = ($urandom_range(299, 0) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
